// File: rtl/leiwand_rv32_wb_interconnect_pkg.sv
// Shared constants, state encoding and sizing helper for the Wishbone interconnect.
package leiwand_rv32_wb_interconnect_pkg;

    localparam int MEM_WIDTH = 32;

    typedef enum logic [1:0] {
        WB_IC_IDLE     = 2'd0,
        WB_IC_WAIT_ACK = 2'd1,
        WB_IC_ERR_RESP = 2'd2
    } wb_ic_state_e;

    // Index of the highest set bit; a counter of this width plus one holds the value.
    function automatic int high_bit_to_fit(input int value);
        int hb;
        hb = 0;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                hb = i;
            end else begin
                hb = hb;
            end
        end
        return hb;
    endfunction

endpackage

// File: rtl/leiwand_rv32_wb_decoder.sv
// Address decoder: per-slave base/size region match, lowest index wins on overlap.
module leiwand_rv32_wb_decoder
    import leiwand_rv32_wb_interconnect_pkg::*;
#(
    parameter int                                NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0]   SLAVE_BASE = {32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0]   SLAVE_SIZE = {32'd512, 32'd512}
) (
    input  logic [MEM_WIDTH-1:0]  m_addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit
);

    logic [NUM_SLAVES-1:0] raw_hit_s;

    // Offset compare instead of base+size so regions touching 2^32 cannot overflow.
    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_region
        localparam logic [MEM_WIDTH-1:0] BASE = SLAVE_BASE[k*MEM_WIDTH +: MEM_WIDTH];
        localparam logic [MEM_WIDTH-1:0] SIZE = SLAVE_SIZE[k*MEM_WIDTH +: MEM_WIDTH];
        logic [MEM_WIDTH-1:0] offset_s;
        assign offset_s     = m_addr - BASE;
        assign raw_hit_s[k] = (m_addr >= BASE) && (offset_s < SIZE);
    end

    // Priority resolution to a one-hot hit vector.
    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (raw_hit_s[k] && !any_hit) begin
                hit[k]  = 1'b1;
                any_hit = 1'b1;
            end else begin
                hit[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone interconnect with muxed read data,
// unmapped-address error and ack timeout.
module leiwand_rv32_wb_interconnect
    import leiwand_rv32_wb_interconnect_pkg::*;
#(
    parameter int                                NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0]   SLAVE_BASE = {32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*MEM_WIDTH-1:0]   SLAVE_SIZE = {32'd512, 32'd512},
    parameter int                                TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            m_cyc,
    input  logic                            m_stb,
    input  logic                            m_we,
    input  logic [MEM_WIDTH-1:0]            m_addr,
    input  logic [MEM_WIDTH-1:0]            m_wdata,
    output logic [MEM_WIDTH-1:0]            m_rdata,
    output logic                            m_ack,
    output logic                            m_err,
    output logic                            m_stall,
    output logic                            s_cyc,
    output logic                            s_we,
    output logic [MEM_WIDTH-1:0]            s_addr,
    output logic [MEM_WIDTH-1:0]            s_wdata,
    output logic [NUM_SLAVES-1:0]           s_stb,
    input  logic [NUM_SLAVES-1:0]           s_ack,
    input  logic [NUM_SLAVES-1:0]           s_stall,
    input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_rdata
);

    localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TIMER_W = high_bit_to_fit(TIMEOUT) + 1;
    // Timer counts completed wait cycles, so the error lands TIMEOUT cycles after accept.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    wb_ic_state_e         state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic [NUM_SLAVES-1:0] hit_s;
    logic                  any_hit_s;
    logic [SEL_W-1:0]      hit_idx_s;
    logic                  req_s;
    logic                  timeout_s;

    leiwand_rv32_wb_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_SIZE (SLAVE_SIZE)
    ) u_decoder (
        .m_addr  (m_addr),
        .hit     (hit_s),
        .any_hit (any_hit_s)
    );

    assign s_cyc     = m_cyc;
    assign s_we      = m_we;
    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign req_s     = m_cyc & m_stb;
    assign timeout_s = (timer_q == TIMER_LAST);

    // One-hot to index; hit vector is already priority-resolved.
    always_comb begin
        hit_idx_s = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            hit_idx_s = hit_idx_s | (hit_s[k] ? SEL_W'(k) : SEL_W'(0));
        end
    end

    // State, selected slave and timeout timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WB_IC_IDLE;
            sel_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        case (state_q)
            WB_IC_IDLE: begin
                if (req_s && any_hit_s && !s_stall[hit_idx_s]) begin
                    state_d = WB_IC_WAIT_ACK;
                    sel_d   = hit_idx_s;
                    timer_d = '0;
                end else if (req_s && !any_hit_s) begin
                    state_d = WB_IC_ERR_RESP;
                end else begin
                    state_d = WB_IC_IDLE;
                end
            end
            WB_IC_WAIT_ACK: begin
                if (!m_cyc || s_ack[sel_q] || timeout_s) begin
                    state_d = WB_IC_IDLE;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 1'b1;
                end else begin
                    timer_d = timer_q;
                end
            end
            WB_IC_ERR_RESP: begin
                state_d = WB_IC_IDLE;
            end
            default: begin
                state_d = WB_IC_IDLE;
            end
        endcase
    end

    // Output logic; reset forces every handshake output low asynchronously.
    always_comb begin
        s_stb   = '0;
        m_stall = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_rdata = '0;
        if (!reset) begin
            s_stb = '0;
        end else begin
            case (state_q)
                WB_IC_IDLE: begin
                    if (req_s) begin
                        s_stb   = hit_s;
                        m_stall = any_hit_s & s_stall[hit_idx_s];
                    end else begin
                        s_stb = '0;
                    end
                end
                WB_IC_WAIT_ACK: begin
                    m_stall = 1'b1;
                    m_rdata = s_rdata[sel_q*MEM_WIDTH +: MEM_WIDTH];
                    m_ack   = m_cyc & s_ack[sel_q];
                    m_err   = m_cyc & ~s_ack[sel_q] & timeout_s;
                end
                WB_IC_ERR_RESP: begin
                    m_stall = 1'b1;
                    m_err   = m_cyc;
                end
                default: begin
                    m_stall = 1'b0;
                end
            endcase
        end
    end

endmodule
